// File: rtl/counter_mod_k_pkg.sv
// Shared types and helpers for the cascaded modulo-k counter.
//   dir_t       : count direction encoding (DIR_DOWN = 0, DIR_UP = 1)
//   stage_slice : extract W-bit field idx from a packed N*W vector
package counter_mod_k_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    // Upper bounds for the slice helper; W <= 32 and N*W <= 256 are supported.
    localparam int unsigned MaxVecBits   = 256;
    localparam int unsigned MaxStageBits = 32;

    function automatic logic [MaxStageBits-1:0] stage_slice(
        input logic [MaxVecBits-1:0] vec,
        input int unsigned           width,
        input int unsigned           idx
    );
        logic [MaxVecBits-1:0] shifted;
        logic [MaxVecBits-1:0] mask;
        shifted = vec >> (idx * width);
        mask    = (MaxVecBits'(1) << width) - MaxVecBits'(1);
        return MaxStageBits'(shifted & mask);
    endfunction

endpackage

// File: rtl/counter_mod_k_stage.sv
// One W-bit up/down modulo-k counter stage.
//   clk, reset : clock, asynchronous active-high reset
//   advance    : step this stage (already qualified by the carry chain)
//   up         : direction, 1 = up, 0 = down
//   clear/load : synchronous clear / parallel load (clear wins)
//   load_val   : value to load
//   k          : runtime modulus; k <= 1 makes the stage a pass-through
//   value      : current count
//   terminal   : combinational, stage is at its wrap point for the current direction
//   carry      : registered, high the cycle after the stage wrapped
module counter_mod_k_stage
    import counter_mod_k_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         advance,
    input  logic         up,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] k,
    output logic [W-1:0] value,
    output logic         terminal,
    output logic         carry
);

    logic [W-1:0] value_q, value_d;
    logic         carry_q, carry_d;
    logic         degenerate;
    logic [W-1:0] k_max;
    dir_t         dir;

    assign dir        = dir_t'(up);
    assign degenerate = (k <= W'(1));
    // k-1 only formed for k >= 2 so it never underflows.
    assign k_max      = degenerate ? '0 : k - W'(1);

    always_comb begin
        terminal = 1'b1;
        if (!degenerate) begin
            if (dir == DIR_UP) terminal = (value_q >= k_max);
            else               terminal = (value_q == '0);
        end
    end

    always_comb begin
        value_d = value_q;
        carry_d = 1'b0;
        if (clear) begin
            value_d = '0;
        end else if (load) begin
            value_d = load_val;
        end else if (advance) begin
            if (degenerate) begin
                value_d = '0;
                carry_d = 1'b1;
            end else if (dir == DIR_UP) begin
                if (terminal) begin
                    value_d = '0;
                    carry_d = 1'b1;
                end else begin
                    value_d = value_q + W'(1);
                end
            end else begin
                if (value_q == '0) begin
                    value_d = k_max;
                    carry_d = 1'b1;
                end else if (value_q > k_max) begin
                    // Out of range after k shrank: clamp without a wrap.
                    value_d = k_max;
                end else begin
                    value_d = value_q - W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            carry_q <= 1'b0;
        end else begin
            value_q <= value_d;
            carry_q <= carry_d;
        end
    end

    assign value = value_q;
    assign carry = carry_q;

endmodule

// File: rtl/counter_mod_k_cascade.sv
// N cascaded W-bit up/down modulo-k counters with per-stage runtime modulus.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_en           : count enable for stage 0 and the whole carry chain
//   i_up           : direction, 1 = up, 0 = down
//   i_clear        : synchronous clear of all stages
//   i_load         : synchronous parallel load from i_load_val
//   i_load_val     : load value, stage j in bits [j*W +: W]
//   i_k            : modulus per stage, same packing
//   o_count        : stage values, same packing
//   o_carry        : per-stage registered wrap pulse
module counter_mod_k_cascade
    import counter_mod_k_pkg::*;
#(
    parameter int unsigned W = 4,
    parameter int unsigned N = 3
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_en,
    input  logic           i_up,
    input  logic           i_clear,
    input  logic           i_load,
    input  logic [N*W-1:0] i_load_val,
    input  logic [N*W-1:0] i_k,
    output logic [N*W-1:0] o_count,
    output logic [N-1:0]   o_carry
);

    logic [N-1:0] advance;
    logic [N-1:0] terminal;

    // Chain is combinational so every stage that wraps does so on the same edge.
    assign advance[0] = i_en;

    for (genvar j = 0; j < N; j++) begin : g_stage
        logic [W-1:0] k_j;
        logic [W-1:0] load_val_j;

        assign k_j        = W'(stage_slice(MaxVecBits'(i_k), W, j));
        assign load_val_j = W'(stage_slice(MaxVecBits'(i_load_val), W, j));

        if (j > 0) begin : g_chain
            assign advance[j] = advance[j-1] & terminal[j-1];
        end

        counter_mod_k_stage #(
            .W (W)
        ) u_stage (
            .clk      (i_clk),
            .reset    (i_reset),
            .advance  (advance[j]),
            .up       (i_up),
            .clear    (i_clear),
            .load     (i_load),
            .load_val (load_val_j),
            .k        (k_j),
            .value    (o_count[j*W +: W]),
            .terminal (terminal[j]),
            .carry    (o_carry[j])
        );
    end

endmodule

// File: tb/tb_counter_mod_k_cascade.sv
module tb_counter_mod_k_cascade;

    localparam int N = 3;
    localparam int W = 4;

    logic           i_clk = 1'b0;
    logic           i_reset;
    logic           i_en;
    logic           i_up;
    logic           i_clear;
    logic           i_load;
    logic [N*W-1:0] i_load_val;
    logic [N*W-1:0] i_k;
    logic [N*W-1:0] o_count;
    logic [N-1:0]   o_carry;

    counter_mod_k_cascade #(
        .W (W),
        .N (N)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_en       (i_en),
        .i_up       (i_up),
        .i_clear    (i_clear),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .i_k        (i_k),
        .o_count    (o_count),
        .o_carry    (o_carry)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [N*W-1:0] cnt;
        logic [N-1:0]   car;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   mv[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: stage values as plain integers, rules applied per stage.
    task automatic model_step(input logic rst, input logic en, input logic up,
                              input logic clr, input logic ld,
                              input logic [N*W-1:0] lv, input logic [N*W-1:0] kv,
                              output exp_t e);
        bit adv;
        e = '0;
        if (rst || clr) begin
            for (int j = 0; j < N; j++) mv[j] = 0;
        end else if (ld) begin
            for (int j = 0; j < N; j++) mv[j] = int'(lv[j*W +: W]);
        end else begin
            adv = en;
            for (int j = 0; j < N; j++) begin
                int  k;
                bit  term;
                bit  wrap;
                int  nv;
                k    = int'(kv[j*W +: W]);
                wrap = 0;
                nv   = mv[j];
                if (k <= 1) begin
                    term = 1;
                    nv   = 0;
                    wrap = 1;
                end else if (up) begin
                    term = (mv[j] >= k - 1);
                    if (term) begin nv = 0; wrap = 1; end
                    else nv = mv[j] + 1;
                end else begin
                    term = (mv[j] == 0);
                    if (mv[j] == 0) begin nv = k - 1; wrap = 1; end
                    else if (mv[j] > k - 1) nv = k - 1;
                    else nv = mv[j] - 1;
                end
                if (adv) begin
                    mv[j]    = nv;
                    e.car[j] = wrap;
                end
                adv = adv && term;
            end
        end
        for (int j = 0; j < N; j++) e.cnt[j*W +: W] = W'(mv[j]);
    endtask

    task automatic drive(input logic rst, input logic en, input logic up,
                         input logic clr, input logic ld,
                         input logic [N*W-1:0] lv, input logic [N*W-1:0] kv);
        exp_t e;
        @(negedge i_clk);
        i_reset    = rst;
        i_en       = en;
        i_up       = up;
        i_clear    = clr;
        i_load     = ld;
        i_load_val = lv;
        i_k        = kv;
        model_step(rst, en, up, clr, ld, lv, kv, e);
        q.push_back(e);
    endtask

    function automatic logic [N*W-1:0] pack3(input int a, input int b, input int c);
        logic [N*W-1:0] v;
        v = {W'(c), W'(b), W'(a)};
        return v;
    endfunction

    // Monitor: one expectation per rising edge, compared just after it.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count", 64'(o_count), 64'(e.cnt));
                chk("carry", 64'(o_carry), 64'(e.car));
            end
        end
    end

    initial begin : stim
        logic [N*W-1:0] kv;
        i_reset    = 1'b1;
        i_en       = 1'b0;
        i_up       = 1'b1;
        i_clear    = 1'b0;
        i_load     = 1'b0;
        i_load_val = '0;
        i_k        = '0;
        for (int j = 0; j < N; j++) mv[j] = 0;
        #1;
        chk("reset_count", 64'(o_count), 64'(0));
        chk("reset_carry", 64'(o_carry), 64'(0));

        repeat (2) drive(1, 1, 1, 0, 0, '0, pack3(3, 3, 3));

        // Up cascade, all k = 3.
        repeat (30) drive(0, 1, 1, 0, 0, '0, pack3(3, 3, 3));
        // Down from a cleared state.
        drive(0, 0, 0, 1, 0, '0, pack3(3, 3, 3));
        repeat (15) drive(0, 1, 0, 0, 0, '0, pack3(3, 3, 3));
        // Degenerate stage 0.
        drive(0, 0, 1, 1, 0, '0, pack3(1, 4, 3));
        repeat (12) drive(0, 1, 1, 0, 0, '0, pack3(1, 4, 3));
        drive(0, 1, 1, 0, 0, '0, pack3(0, 4, 3));
        // Priority: clear beats load beats a would-be wrap.
        drive(0, 0, 1, 0, 1, pack3(2, 2, 2), pack3(3, 3, 3));
        drive(0, 1, 1, 1, 1, pack3(1, 1, 1), pack3(3, 3, 3));
        drive(0, 0, 1, 0, 1, pack3(2, 0, 0), pack3(3, 3, 3));
        drive(0, 0, 1, 0, 0, '0, pack3(3, 3, 3));
        // k shrink 8 -> 4 with stage 0 at 5, up then down.
        drive(0, 0, 1, 0, 1, pack3(5, 0, 0), pack3(8, 8, 8));
        drive(0, 1, 1, 0, 0, '0, pack3(4, 8, 8));
        drive(0, 0, 1, 0, 1, pack3(5, 1, 0), pack3(8, 8, 8));
        drive(0, 1, 0, 0, 0, '0, pack3(4, 8, 8));
        drive(0, 1, 0, 0, 0, '0, pack3(4, 8, 8));

        // Randomized run; k changes occasionally so wraps still happen.
        kv = pack3(3, 5, 2);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                int s;
                s = $urandom_range(0, N - 1);
                kv[s*W +: W] = W'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) kv[s*W +: W] = W'($urandom_range(0, 4));
            end
            drive(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 49) == 0), ($urandom_range(0, 39) == 0),
                  (N*W)'($urandom), kv);
        end

        // Async reset between edges while counting.
        repeat (5) drive(0, 1, 1, 0, 0, '0, pack3(2, 2, 2));
        @(posedge i_clk);
        #3;
        i_reset = 1'b1;
        #1;
        chk("async_rst_count", 64'(o_count), 64'(0));
        chk("async_rst_carry", 64'(o_carry), 64'(0));
        for (int j = 0; j < N; j++) mv[j] = 0;
        drive(1, 1, 1, 0, 0, '0, pack3(3, 3, 3));
        repeat (4) drive(0, 1, 1, 0, 0, '0, pack3(3, 3, 3));

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 10 && q.size() > 0; t++) begin
            @(posedge i_clk);
            #2;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_mod_k_cascade.md
# counter_mod_k_cascade

Parametrised, multi-stage, up/down modulo-k counter with a per-stage runtime modulus and registered per-stage carry pulses. It generalises the single-stage modulo-k rollover counter: N stages chained by carry (e.g. clock divider plus digit/time-of-day counters), a direction mode, synchronous clear and parallel load. It sits in the timing/sequencing layer and feeds enable pulses to downstream blocks.

## Interface
- W, default 4: width of one stage, in bits.
- N, default 3: number of cascaded stages. Stage 0 is least significant.
- i_clk  in  1  clock. All state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_en  in  1  count enable; advances stage 0 and gates the whole carry chain.
- i_up  in  1  direction: 1 = up, 0 = down. Sampled every edge.
- i_clear  in  1  synchronous clear of all stages to 0.
- i_load  in  1  synchronous parallel load from i_load_val.
- i_load_val  in  N*W  load value; stage j in bits [j*W +: W].
- i_k  in  N*W  modulus per stage; stage j in bits [j*W +: W].
- o_count  out  N*W  current stage values, same packing.
- o_carry  out  N  per-stage registered wrap pulse.

## Operation
- Edge priority: i_reset > i_clear > i_load > i_en. Clear and load never produce carry pulses.
- Advance condition: stage 0 advances when i_en=1. Stage j>0 advances when i_en=1 and every stage below j is terminal in the current cycle.
- Terminal, up: value >= k-1. Terminal, down: value == 0.
- Up advance: terminal -> 0 and the stage wraps; otherwise value+1.
- Down advance: value == 0 -> k-1 and the stage wraps. value > k-1 (after k shrank) -> k-1 with no wrap. Otherwise value-1.
- k == 0 or k == 1: the stage holds 0, is always terminal, and wraps on every advance. The stage is a pass-through in the chain.
- i_k may change at any time. The new modulus applies from the next edge. No state is kept about the old k.
- Load values >= k are accepted unmodified and are resolved by the rules above.
- All arithmetic is W bits, unsigned. k-1 is computed only for k >= 2, so there is no underflow.
- Direction change takes effect on the next edge. No reset of values.

## Timing
- Reset values: o_count = 0 and o_carry = 0, both immediately on i_reset assertion (asynchronous) and held while i_reset is high.
- o_count latency: the updated value is visible right after the edge that advanced it.
- o_carry[j] latency: a flop set at the edge where stage j wraps. It is high for exactly the following cycle. On continuous wrapping (k <= 1) it stays high.
- Carry-chain evaluation is combinational within one cycle, so all stages wrap on the same edge. o_carry[N-1] = 1 implies o_carry[0..N-2] = 1 in the same cycle.
- Clear or load on the same edge as a would-be wrap: the wrap is suppressed and o_carry = 0 next cycle.
- Reset mid-count, between edges: outputs go to 0 without waiting for an edge. Counting resumes from 0 at the first edge after release.

## Structure
- Package counter_mod_k_pkg holds:
  - enum dir_t: DIR_DOWN = 0, DIR_UP = 1.
  - The stage-slice helper function (extract a W-bit field j from an N*W vector).
- Sub-module counter_mod_k_stage implements one W-bit stage:
  - inputs: clk, reset, advance, up, clear, load, load_val, k.
  - outputs: value, terminal (combinational), carry (registered).
- The top level instantiates N stages with a generate loop. It builds the advance chain as advance[j] = i_en & terminal[0] & … & terminal[j-1].

## Test plan
- Up cascade: N=2, W=2, k = 3/3, i_up=1, i_en=1 from reset. o_count stage 0 steps 0,1,2,0,… o_carry[0] is high every 3rd cycle. o_carry[1] is high every 9th cycle, coinciding with o_carry[0]. Stage 1 steps 0,1,2.
- Down from reset: k = 3/3, i_up=0. The first edge gives 2/2 with o_carry = 2'b11 in the next cycle. Then stage 0 steps 1, 0, then 2 while stage 1 steps to 1.
- Degenerate modulus: k0=1, k1=4, up, i_en=1. Stage 0 holds 0 and o_carry[0] stays 1. Stage 1 steps 0,1,2,3,0, with o_carry[1] pulsing every 4th cycle.
- Priority: stage 0 at k-1 with i_clear=1, i_load=1, i_en=1. Next cycle o_count=0 and o_carry=0. Then load val 2, en=0: o_count stage 0 = 2, no carry.
- k shrink: W=4, stage 0 at 5, k0 changed 8 -> 4. Up with en gives 0 plus an o_carry[0] pulse. Down instead gives 3 with no carry.
- Async reset: assert i_reset mid-cycle while counting. o_count and o_carry are 0 before the next edge. After release, the first enabled edge gives stage 0 = 1 (up).
